mips_multicycle_ctrl: RTL and testbench
=======================================

MIPS_MULTICYCLE_CTRL -- requirements
Module: mips_multicycle_ctrl

Interface
REQ-001 The block SHALL have no parameters; all encodings are fixed constants.
REQ-002 clk  input  1  sole clock; all state changes occur on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 op  input  6  instruction opcode (instr[31:26]), valid while ir holds the current instruction.
REQ-005 funct  input  6  R-type function field (instr[5:0]).
REQ-006 zero  input  1  ALU zero flag from the ALU driven by alu_ctrl, same cycle.
REQ-007 alu_ctrl  output  3  ALU operation: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT.
REQ-008 alu_src_a  output  1  0 = PC, 1 = register A.
REQ-009 alu_src_b  output  2  00 = register B, 01 = constant 4, 10 = sign-extended imm, 11 = sign-extended imm shifted left by 2.
REQ-010 pc_src  output  2  00 = ALU result, 01 = ALUOut register, 10 = jump target.
REQ-011 iord, ir_write, mem_write, reg_write, reg_dst, mem_to_reg  output  1 each  standard multicycle datapath strobes and selects.
REQ-012 pc_en  output  1  PC register load enable.
REQ-013 state  output  4  current FSM state, for debug and verification.

Function
REQ-014 States and encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11.
REQ-015 Opcode transitions:
- FETCH->DECODE.
- DECODE->MEMADR on lw (100011) or sw (101011).
- DECODE->EXECUTE on R-type (000000).
- DECODE->BRANCH on beq (000100).
- DECODE->ADDIEX on addi (001000).
- DECODE->JUMP on j (000010).
- DECODE->FETCH on any other opcode (treated as NOP).
REQ-016 Memory and completion transitions:
- MEMADR->MEMRD on lw, MEMADR->MEMWR on sw.
- MEMRD->MEMWB.
- EXECUTE->ALUWB.
- ADDIEX->ADDIWB.
- MEMWB, MEMWR, ALUWB, ADDIWB, BRANCH and JUMP each ->FETCH.
- Unused encodings 12-15 ->FETCH.
REQ-017 All strobes and selects SHALL be decoded from state alone (Moore), default 0 / 00 in every state that does not assert them.
REQ-018 Strobes and selects asserted per state:
- FETCH: ir_write=1, pc_write=1, alu_src_b=01, ADD.
- DECODE: alu_src_b=11, ADD.
- MEMADR and ADDIEX: alu_src_a=1, alu_src_b=10, ADD.
- MEMRD: iord=1.
- MEMWB: reg_write=1, mem_to_reg=1.
- MEMWR: iord=1, mem_write=1.
- EXECUTE: alu_src_a=1, alu_src_b=00, alu_ctrl from funct.
- ALUWB: reg_write=1, reg_dst=1.
- BRANCH: alu_src_a=1, alu_src_b=00, SUB, pc_src=01, branch=1.
- ADDIWB: reg_write=1.
- JUMP: pc_src=10, pc_write=1.
REQ-019 pc_en SHALL equal pc_write OR (branch AND zero), combinational in the same cycle; pc_write and branch are internal state-decoded signals.
REQ-020 alu_op is internal, 2 bits: 00 ADD, 01 SUB, 10 funct-decoded.
REQ-021 Funct decode: 100000->010, 100010->110, 100100->000, 100101->001, 101010->111; any other funct SHALL give 010.
REQ-022 Latency: beq and j take 3 cycles; R-type, addi and sw take 4; lw takes 5.
REQ-023 No output SHALL depend on op or funct except alu_ctrl (via funct in EXECUTE) and next-state selection.

Reset
REQ-024 On a rising clk edge with reset=1, state SHALL become FETCH regardless of the current state, including mid-instruction.
REQ-025 From the cycle after that edge, outputs SHALL show FETCH values until the next edge without reset: ir_write=1, pc_en=1, alu_src_b=01, alu_ctrl=010, all others 0.
REQ-026 Holding reset for multiple cycles SHALL keep state at FETCH; no other storage requires reset.

Structure
REQ-027 Opcode, funct, alu_ctrl and state encodings SHALL live in the shared MIPS definitions package/header, shared with the ALU and datapath.
REQ-028 Funct/alu_op-to-alu_ctrl decoding SHALL be a separate combinational sub-module, alu_decoder; the FSM and output decode stay in mips_multicycle_ctrl.

Verification
REQ-029 Reset, then op=100011 (lw) -> state sequence 0,1,2,3,4,0; reg_write=1 and mem_to_reg=1 only in state 4.
REQ-030 op=000000, funct=101010 (slt) -> alu_ctrl=111 in EXECUTE; reg_write=1 and reg_dst=1 in ALUWB; back to FETCH after 4 cycles.
REQ-031 op=000100 with zero=1 in BRANCH -> pc_en=1, pc_src=01; repeat with zero=0 -> pc_en=0; both return to FETCH after 3 cycles.
REQ-032 op=101011 (sw) -> states 0,1,2,5,0; mem_write=1 and iord=1 only in state 5; reg_write never 1.
REQ-033 Illegal op=111111 -> DECODE->FETCH; no reg_write or mem_write pulse.
REQ-034 reset asserted in MEMRD -> state=0 next cycle, mem_to_reg=0; then a fresh j (000010) runs 0,1,11,0 with pc_src=10 and pc_en=1 in JUMP.

Source files
------------

// File: rtl/mips_multicycle_ctrl_pkg.sv
// Shared MIPS definitions for the multicycle controller, ALU and datapath.
// Holds the FSM state encoding, opcode and funct field values, ALU control
// codes, the internal alu_op encoding and the datapath mux select codes.
package mips_multicycle_ctrl_pkg;

  // FSM states. The encodings are visible on the debug 'state' port.
  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
  } state_t;

  // Opcodes, instr[31:26].
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // R-type function field, instr[5:0].
  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  // ALU control codes understood by the ALU.
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // Internal request from the FSM to the ALU decoder.
  typedef enum logic [1:0] {
    ALU_OP_ADD   = 2'b00,
    ALU_OP_SUB   = 2'b01,
    ALU_OP_FUNCT = 2'b10
  } alu_op_t;

  // ALU B-operand select.
  localparam logic [1:0] SRC_B_REG     = 2'b00;
  localparam logic [1:0] SRC_B_FOUR    = 2'b01;
  localparam logic [1:0] SRC_B_IMM     = 2'b10;
  localparam logic [1:0] SRC_B_IMM_SH2 = 2'b11;

  // Next-PC select.
  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  // Loads and stores share the address-calculation state.
  function automatic logic is_mem_op(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/mips_multicycle_ctrl_alu_decoder.sv
// ALU decoder: turns the FSM's alu_op request and the R-type funct field
// into the 3-bit ALU control code.
// Ports:
//   alu_op   in  2  00 ADD, 01 SUB, 10 decode from funct
//   funct    in  6  R-type function field
//   alu_ctrl out 3  ALU operation code
module alu_decoder
  import mips_multicycle_ctrl_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [5:0] funct,
  output logic [2:0] alu_ctrl
);

  always_comb begin
    // NOTE: a default assignment ahead of the case keeps every path driven,
    // so no latch is inferred for encodings the case does not list.
    alu_ctrl = ALU_ADD;
    case (alu_op)
      ALU_OP_ADD: alu_ctrl = ALU_ADD;
      ALU_OP_SUB: alu_ctrl = ALU_SUB;
      ALU_OP_FUNCT: begin
        case (funct)
          FUNCT_ADD: alu_ctrl = ALU_ADD;
          FUNCT_SUB: alu_ctrl = ALU_SUB;
          FUNCT_AND: alu_ctrl = ALU_AND;
          FUNCT_OR:  alu_ctrl = ALU_OR;
          FUNCT_SLT: alu_ctrl = ALU_SLT;
          // Unknown R-type functions fall back to ADD.
          default:   alu_ctrl = ALU_ADD;
        endcase
      end
      // alu_op 11 is never requested; treat it as ADD.
      default: alu_ctrl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS controller: a Moore FSM that sequences fetch, decode and
// the per-instruction execute/memory/writeback steps for lw, sw, R-type,
// beq, addi and j. Unknown opcodes are treated as NOPs.
// Ports:
//   clk        in  1  clock, rising edge
//   reset      in  1  synchronous, active-high; forces FETCH
//   op         in  6  opcode of the instruction held in IR
//   funct      in  6  R-type function field of the instruction in IR
//   zero       in  1  ALU zero flag (same cycle)
//   alu_ctrl   out 3  ALU operation
//   alu_src_a  out 1  0 PC, 1 register A
//   alu_src_b  out 2  00 B, 01 four, 10 imm, 11 imm<<2
//   pc_src     out 2  00 ALU result, 01 ALUOut, 10 jump target
//   iord       out 1  memory address from ALUOut instead of PC
//   ir_write   out 1  load IR
//   mem_write  out 1  memory write strobe
//   reg_write  out 1  register file write strobe
//   reg_dst    out 1  write register is rd (else rt)
//   mem_to_reg out 1  write data from memory data register (else ALUOut)
//   pc_en      out 1  PC load enable
//   state      out 4  current FSM state (debug)
module mips_multicycle_ctrl
  import mips_multicycle_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic [2:0] alu_ctrl,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_src,
  output logic       iord,
  output logic       ir_write,
  output logic       mem_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       pc_en,
  output logic [3:0] state
);

  state_t  state_q;
  alu_op_t alu_op;
  logic    pc_write;
  logic    branch;

  // NOTE: the state register is the only storage in this block and the only
  // thing reset touches; everything else is decoded from it each cycle.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      state_q <= S_FETCH;
    end else begin
      case (state_q)
        S_FETCH:  state_q <= S_DECODE;
        S_DECODE: begin
          if (is_mem_op(op))        state_q <= S_MEMADR;
          else if (op == OP_RTYPE)  state_q <= S_EXECUTE;
          else if (op == OP_BEQ)    state_q <= S_BRANCH;
          else if (op == OP_ADDI)   state_q <= S_ADDIEX;
          else if (op == OP_J)      state_q <= S_JUMP;
          else                      state_q <= S_FETCH;
        end
        S_MEMADR: begin
          if (op == OP_LW)          state_q <= S_MEMRD;
          else if (op == OP_SW)     state_q <= S_MEMWR;
          // IR cannot change here, but recover cleanly if it somehow did.
          else                      state_q <= S_FETCH;
        end
        S_MEMRD:   state_q <= S_MEMWB;
        S_EXECUTE: state_q <= S_ALUWB;
        S_ADDIEX:  state_q <= S_ADDIWB;
        S_MEMWB, S_MEMWR, S_ALUWB, S_ADDIWB, S_BRANCH, S_JUMP:
                   state_q <= S_FETCH;
        // Encodings 12-15 are unreachable; return to FETCH if one appears.
        default:   state_q <= S_FETCH;
      endcase
    end
  end

  // Moore output decode: every strobe and select depends on state only.
  always_comb begin
    alu_op     = ALU_OP_ADD;
    alu_src_a  = 1'b0;
    alu_src_b  = SRC_B_REG;
    pc_src     = PC_SRC_ALU;
    iord       = 1'b0;
    ir_write   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    pc_write   = 1'b0;
    branch     = 1'b0;
    case (state_q)
      S_FETCH: begin
        ir_write  = 1'b1;
        pc_write  = 1'b1;
        alu_src_b = SRC_B_FOUR;
      end
      // Precompute the branch target into ALUOut while decoding.
      S_DECODE: alu_src_b = SRC_B_IMM_SH2;
      S_MEMADR, S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRC_B_IMM;
      end
      S_MEMRD: iord = 1'b1;
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        iord      = 1'b1;
        mem_write = 1'b1;
      end
      S_EXECUTE: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_OP_FUNCT;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      // A - B is compared here; the PC takes the target held in ALUOut.
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_OP_SUB;
        pc_src    = PC_SRC_ALUOUT;
        branch    = 1'b1;
      end
      S_ADDIWB: reg_write = 1'b1;
      S_JUMP: begin
        pc_src   = PC_SRC_JUMP;
        pc_write = 1'b1;
      end
      default: ;
    endcase
  end

  alu_decoder u_alu_decoder (
    .alu_op   (alu_op),
    .funct    (funct),
    .alu_ctrl (alu_ctrl)
  );

  // zero comes from the ALU in the same cycle, so the branch decision is
  // taken combinationally in BRANCH.
  assign pc_en = pc_write | (branch & zero);
  assign state = state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed testbench for mips_multicycle_ctrl. Each task runs one
// instruction or scenario and compares state plus a packed output vector
// against hand-computed constants every cycle.
module tb_mips_multicycle_ctrl;
  import mips_multicycle_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic [2:0] alu_ctrl;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] pc_src;
  logic       iord, ir_write, mem_write, reg_write, reg_dst, mem_to_reg, pc_en;
  logic [3:0] state;

  int checks = 0;
  int errors = 0;

  mips_multicycle_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .funct      (funct),
    .zero       (zero),
    .alu_ctrl   (alu_ctrl),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .pc_src     (pc_src),
    .iord       (iord),
    .ir_write   (ir_write),
    .mem_write  (mem_write),
    .reg_write  (reg_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .pc_en      (pc_en),
    .state      (state)
  );

  always #5 clk = ~clk;

  // Packed output layout:
  // {alu_ctrl[3], alu_src_a, alu_src_b[2], pc_src[2], iord, ir_write,
  //  mem_write, reg_write, reg_dst, mem_to_reg, pc_en}
  localparam logic [14:0] V_FETCH   = 15'b010_0_01_00_0_1_0_0_0_0_1;
  localparam logic [14:0] V_DECODE  = 15'b010_0_11_00_0_0_0_0_0_0_0;
  localparam logic [14:0] V_MEMADR  = 15'b010_1_10_00_0_0_0_0_0_0_0;
  localparam logic [14:0] V_MEMRD   = 15'b010_0_00_00_1_0_0_0_0_0_0;
  localparam logic [14:0] V_MEMWB   = 15'b010_0_00_00_0_0_0_1_0_1_0;
  localparam logic [14:0] V_MEMWR   = 15'b010_0_00_00_1_0_1_0_0_0_0;
  localparam logic [14:0] V_EXE_SLT = 15'b111_1_00_00_0_0_0_0_0_0_0;
  localparam logic [14:0] V_ALUWB   = 15'b010_0_00_00_0_0_0_1_1_0_0;
  localparam logic [14:0] V_BR_TAKE = 15'b110_1_00_01_0_0_0_0_0_0_1;
  localparam logic [14:0] V_BR_NOT  = 15'b110_1_00_01_0_0_0_0_0_0_0;
  localparam logic [14:0] V_ADDIWB  = 15'b010_0_00_00_0_0_0_1_0_0_0;
  localparam logic [14:0] V_JUMP    = 15'b010_0_00_10_0_0_0_0_0_0_1;

  function automatic logic [14:0] outs();
    return {alu_ctrl, alu_src_a, alu_src_b, pc_src, iord, ir_write,
            mem_write, reg_write, reg_dst, mem_to_reg, pc_en};
  endfunction

  // Advance one clock and settle away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    op    = OP_LW;
    funct = 6'd0;
    zero  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (state !== 4'd0) begin
        errors++;
        $display("FAIL reset_state cyc%0d got %0d want 0", i, state);
      end
      checks++;
      if (outs() !== V_FETCH) begin
        errors++;
        $display("FAIL reset_outs cyc%0d got %b want %b", i, outs(), V_FETCH);
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_lw();
    logic [3:0]  st [6] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
    logic [14:0] ev [6] = '{V_FETCH, V_DECODE, V_MEMADR, V_MEMRD, V_MEMWB, V_FETCH};
    op = OP_LW; funct = 6'd0; zero = 1'b0;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (state !== st[i]) begin
        errors++;
        $display("FAIL lw_state[%0d] got %0d want %0d", i, state, st[i]);
      end
      checks++;
      if (outs() !== ev[i]) begin
        errors++;
        $display("FAIL lw_outs[%0d] got %b want %b", i, outs(), ev[i]);
      end
      if (i != 5) step();
    end
  endtask

  task automatic test_rtype_slt();
    logic [3:0]  st [5] = '{4'd0, 4'd1, 4'd6, 4'd7, 4'd0};
    logic [14:0] ev [5] = '{V_FETCH, V_DECODE, V_EXE_SLT, V_ALUWB, V_FETCH};
    op = OP_RTYPE; funct = FUNCT_SLT; zero = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (state !== st[i]) begin
        errors++;
        $display("FAIL slt_state[%0d] got %0d want %0d", i, state, st[i]);
      end
      checks++;
      if (outs() !== ev[i]) begin
        errors++;
        $display("FAIL slt_outs[%0d] got %b want %b", i, outs(), ev[i]);
      end
      if (i != 4) step();
    end
  endtask

  // alu_ctrl in EXECUTE for each funct, including an unknown one.
  task automatic test_funct_decode();
    logic [5:0] fn  [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b000111};
    logic [2:0] exp [5] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b010};
    op = OP_RTYPE; zero = 1'b0;
    for (int i = 0; i < 5; i++) begin
      funct = fn[i];
      step(); step();
      checks++;
      if (state !== 4'd6 || alu_ctrl !== exp[i] || alu_src_a !== 1'b1) begin
        errors++;
        $display("FAIL funct_%b got state %0d alu_ctrl %b src_a %b want 6 %b 1",
                 fn[i], state, alu_ctrl, alu_src_a, exp[i]);
      end
      step(); step();
      checks++;
      if (state !== 4'd0) begin
        errors++;
        $display("FAIL funct_%b_return got %0d want 0", fn[i], state);
      end
    end
  endtask

  task automatic test_beq(input logic z);
    logic [3:0]  st [4] = '{4'd0, 4'd1, 4'd8, 4'd0};
    logic [14:0] ev [4];
    ev = '{V_FETCH, V_DECODE, (z ? V_BR_TAKE : V_BR_NOT), V_FETCH};
    op = OP_BEQ; funct = FUNCT_AND; zero = z;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (state !== st[i]) begin
        errors++;
        $display("FAIL beq_z%0b_state[%0d] got %0d want %0d", z, i, state, st[i]);
      end
      checks++;
      if (outs() !== ev[i]) begin
        errors++;
        $display("FAIL beq_z%0b_outs[%0d] got %b want %b", z, i, outs(), ev[i]);
      end
      if (i != 3) step();
    end
  endtask

  task automatic test_sw();
    logic [3:0]  st [5] = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd0};
    logic [14:0] ev [5] = '{V_FETCH, V_DECODE, V_MEMADR, V_MEMWR, V_FETCH};
    op = OP_SW; funct = 6'd0; zero = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (state !== st[i]) begin
        errors++;
        $display("FAIL sw_state[%0d] got %0d want %0d", i, state, st[i]);
      end
      checks++;
      if (outs() !== ev[i]) begin
        errors++;
        $display("FAIL sw_outs[%0d] got %b want %b", i, outs(), ev[i]);
      end
      if (i != 4) step();
    end
  endtask

  task automatic test_addi();
    logic [3:0]  st [5] = '{4'd0, 4'd1, 4'd9, 4'd10, 4'd0};
    logic [14:0] ev [5] = '{V_FETCH, V_DECODE, V_MEMADR, V_ADDIWB, V_FETCH};
    op = OP_ADDI; funct = FUNCT_SLT; zero = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (state !== st[i]) begin
        errors++;
        $display("FAIL addi_state[%0d] got %0d want %0d", i, state, st[i]);
      end
      checks++;
      if (outs() !== ev[i]) begin
        errors++;
        $display("FAIL addi_outs[%0d] got %b want %b", i, outs(), ev[i]);
      end
      if (i != 4) step();
    end
  endtask

  task automatic test_illegal();
    logic [3:0]  st [3] = '{4'd0, 4'd1, 4'd0};
    logic [14:0] ev [3] = '{V_FETCH, V_DECODE, V_FETCH};
    op = 6'b111111; funct = FUNCT_SUB; zero = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (state !== st[i]) begin
        errors++;
        $display("FAIL illegal_state[%0d] got %0d want %0d", i, state, st[i]);
      end
      checks++;
      if (outs() !== ev[i]) begin
        errors++;
        $display("FAIL illegal_outs[%0d] got %b want %b", i, outs(), ev[i]);
      end
      if (i != 2) step();
    end
  endtask

  // Reset in MEMRD of a load, then a fresh jump.
  task automatic test_reset_mid_then_jump();
    logic [3:0]  st [4] = '{4'd0, 4'd1, 4'd11, 4'd0};
    logic [14:0] ev [4] = '{V_FETCH, V_DECODE, V_JUMP, V_FETCH};
    op = OP_LW; funct = 6'd0; zero = 1'b0;
    step(); step(); step();
    checks++;
    if (state !== 4'd3) begin
      errors++;
      $display("FAIL midrst_pre got %0d want 3", state);
    end
    reset = 1'b1;
    step();
    checks++;
    if (state !== 4'd0 || mem_to_reg !== 1'b0 || outs() !== V_FETCH) begin
      errors++;
      $display("FAIL midrst_post got state %0d outs %b want 0 %b", state, outs(), V_FETCH);
    end
    reset = 1'b0;
    op = OP_J;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (state !== st[i]) begin
        errors++;
        $display("FAIL jump_state[%0d] got %0d want %0d", i, state, st[i]);
      end
      checks++;
      if (outs() !== ev[i]) begin
        errors++;
        $display("FAIL jump_outs[%0d] got %b want %b", i, outs(), ev[i]);
      end
      if (i != 3) step();
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_rtype_slt();
    test_funct_decode();
    test_beq(1'b1);
    test_beq(1'b0);
    test_sw();
    test_addi();
    test_illegal();
    test_reset_mid_then_jump();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
